// File: rtl/change_dispenser.sv
// Refund payout controller: pays an amount in nickel units one coin at a time.
// Coins are chosen greedily (quarter, dime, nickel) and only while inventory remains.
module change_dispenser #(
    parameter int AMT_W       = 5,
    parameter int MAX_UNITS   = 20,
    parameter int CNT_W       = 6,
    parameter int Q_INIT      = 8,
    parameter int D_INIT      = 8,
    parameter int N_INIT      = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int GAP_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             refill,
    input  logic             hopper_ack,
    output logic             eject_quarter,
    output logic             eject_dime,
    output logic             eject_nickel,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] q_count,
    output logic [CNT_W-1:0] d_count,
    output logic [CNT_W-1:0] n_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_EJECT, S_GAP, S_FINISH, S_FAULT
    } state_t;

    localparam int TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(MAX_UNITS);

    state_t             state_reg, state_next;
    logic [AMT_W-1:0]   rem_reg, rem_next;
    logic [2:0]         sel_reg, sel_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic               short_reg, short_next;

    logic               take;
    logic               reload;
    logic [2:0]         avail;
    logic [2:0]         pick;
    logic [AMT_W-1:0]   sel_val;
    logic [AMT_W-1:0]   coin_val [3];
    logic [CNT_W-1:0]   cnt_vec  [3];

    assign take   = (state_reg == S_EJECT) && hopper_ack;
    assign reload = refill && ((state_reg == S_IDLE) || (state_reg == S_FAULT));

    // Index 0 = quarter, 1 = dime, 2 = nickel; lower index wins the greedy pick.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_coin
            localparam int VAL_I  = (gi == 0) ? 5 : (gi == 1) ? 2 : 1;
            localparam int INIT_I = (gi == 0) ? Q_INIT : (gi == 1) ? D_INIT : N_INIT;
            logic [CNT_W-1:0] cnt_reg;

            assign coin_val[gi] = AMT_W'(VAL_I);
            assign cnt_vec[gi]  = cnt_reg;
            assign avail[gi]    = (cnt_reg != '0) && (rem_reg >= AMT_W'(VAL_I));

            always_ff @(posedge clk) begin
                if (!reset_n || reload) begin
                    cnt_reg <= CNT_W'(INIT_I);
                end else if (take && sel_reg[gi]) begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        pick = 3'b000;
        if (avail[0])      pick = 3'b001;
        else if (avail[1]) pick = 3'b010;
        else if (avail[2]) pick = 3'b100;
    end

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < 3; i++) begin
            if (sel_reg[i]) sel_val = sel_val | coin_val[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            rem_reg   <= '0;
            sel_reg   <= '0;
            timer_reg <= '0;
            short_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            sel_reg   <= sel_next;
            timer_reg <= timer_next;
            short_reg <= short_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        sel_next   = sel_reg;
        timer_next = timer_reg;
        short_next = short_reg;
        case (state_reg)
            S_IDLE: begin
                if (!refill && start) begin
                    rem_next   = amount;
                    short_next = (amount > MAX_AMT);
                    state_next = (amount > MAX_AMT) ? S_FINISH : S_SELECT;
                end
            end
            S_SELECT: begin
                timer_next = '0;
                if (pick != 3'b000) begin
                    sel_next   = pick;
                    state_next = S_EJECT;
                end else begin
                    short_next = (rem_reg != '0);
                    state_next = S_FINISH;
                end
            end
            S_EJECT: begin
                // Selection guaranteed rem >= coin value, so this cannot wrap.
                if (hopper_ack) begin
                    rem_next   = rem_reg - sel_val;
                    timer_next = '0;
                    state_next = S_GAP;
                end else if (timer_reg == TMR_W'(ACK_TIMEOUT - 1)) begin
                    state_next = S_FAULT;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            S_GAP: begin
                if (timer_reg == TMR_W'(GAP_CYCLES - 1)) begin
                    state_next = S_SELECT;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            S_FINISH: state_next = S_IDLE;
            S_FAULT: begin
                if (refill) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        eject_quarter = 1'b0;
        eject_dime    = 1'b0;
        eject_nickel  = 1'b0;
        if (state_reg == S_EJECT) begin
            eject_quarter = sel_reg[0];
            eject_dime    = sel_reg[1];
            eject_nickel  = sel_reg[2];
        end
        busy  = (state_reg != S_IDLE);
        done  = (state_reg == S_FINISH);
        fault = (state_reg == S_FAULT);
    end

    assign short     = short_reg;
    assign remaining = rem_reg;
    assign q_count   = cnt_vec[0];
    assign d_count   = cnt_vec[1];
    assign n_count   = cnt_vec[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected ejects/done/fault
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_change_dispenser;

    localparam int AMT_W = 5;
    localparam int CNT_W = 6;
    localparam int EV_EJECT = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_FAULT = 2;
    localparam logic [2:0] C_Q = 3'b100;
    localparam logic [2:0] C_D = 3'b010;
    localparam logic [2:0] C_N = 3'b001;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             refill;
    logic             hopper_ack;
    logic             eject_quarter, eject_dime, eject_nickel;
    logic             busy, done, short, fault;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] q_count, d_count, n_count;

    logic ack_en;
    logic ack_force;
    int   ack_age;

    typedef struct {
        int               kind;
        logic [2:0]       coin;
        logic             short_v;
        logic [AMT_W-1:0] rem;
        logic [CNT_W-1:0] q;
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] n;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    change_dispenser #(
        .AMT_W(AMT_W), .MAX_UNITS(20), .CNT_W(CNT_W),
        .Q_INIT(8), .D_INIT(8), .N_INIT(8),
        .ACK_TIMEOUT(255), .GAP_CYCLES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .amount(amount),
        .refill(refill), .hopper_ack(hopper_ack),
        .eject_quarter(eject_quarter), .eject_dime(eject_dime), .eject_nickel(eject_nickel),
        .busy(busy), .done(done), .short(short), .fault(fault),
        .remaining(remaining), .q_count(q_count), .d_count(d_count), .n_count(n_count)
    );

    // Hopper model: acknowledges on the second cycle an eject line is seen high.
    assign hopper_ack = (ack_en && (ack_age >= 2)) || ack_force;

    initial begin
        ack_age = 0;
        forever begin
            @(negedge clk);
            if (eject_quarter || eject_dime || eject_nickel) ack_age++;
            else ack_age = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_eject(input logic [2:0] c);
        exp_t e;
        e.kind = EV_EJECT; e.coin = c; e.short_v = 1'b0; e.rem = '0;
        e.q = '0; e.d = '0; e.n = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic s, input int r, input int q, input int d, input int n);
        exp_t e;
        e.kind = EV_DONE; e.coin = 3'b000; e.short_v = s; e.rem = AMT_W'(r);
        e.q = CNT_W'(q); e.d = CNT_W'(d); e.n = CNT_W'(n);
        exp_q.push_back(e);
    endtask

    task automatic push_fault(input int r, input int q, input int d, input int n);
        exp_t e;
        e.kind = EV_FAULT; e.coin = 3'b000; e.short_v = 1'b0; e.rem = AMT_W'(r);
        e.q = CNT_W'(q); e.d = CNT_W'(d); e.n = CNT_W'(n);
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        logic [2:0] prev_ej;
        logic       prev_fault;
        logic [2:0] ej;
        exp_t       e;
        prev_ej = 3'b000;
        prev_fault = 1'b0;
        forever begin
            @(negedge clk);
            ej = {eject_quarter, eject_dime, eject_nickel};
            if (reset_n) begin
                if (ej != 3'b000 && prev_ej == 3'b000) begin
                    if (exp_q.size() == 0) check("unexpected_eject", 32'(ej), 0);
                    else begin
                        e = exp_q.pop_front();
                        check("eject_event_kind", e.kind, EV_EJECT);
                        check("eject_coin", 32'(ej), 32'(e.coin));
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) check("unexpected_done", 32'(done), 0);
                    else begin
                        e = exp_q.pop_front();
                        check("done_event_kind", e.kind, EV_DONE);
                        check("done_short", 32'(short), 32'(e.short_v));
                        check("done_remaining", 32'(remaining), 32'(e.rem));
                        check("done_q_count", 32'(q_count), 32'(e.q));
                        check("done_d_count", 32'(d_count), 32'(e.d));
                        check("done_n_count", 32'(n_count), 32'(e.n));
                    end
                end
                if (fault && !prev_fault) begin
                    if (exp_q.size() == 0) check("unexpected_fault", 32'(fault), 0);
                    else begin
                        e = exp_q.pop_front();
                        check("fault_event_kind", e.kind, EV_FAULT);
                        check("fault_eject_low", 32'(ej), 32'(e.coin));
                        check("fault_busy", 32'(busy), 1);
                        check("fault_remaining", 32'(remaining), 32'(e.rem));
                        check("fault_n_count", 32'(n_count), 32'(e.n));
                    end
                end
                prev_ej = ej;
                prev_fault = fault;
            end else begin
                prev_ej = 3'b000;
                prev_fault = 1'b0;
            end
        end
    end

    task automatic run_req(input int amt);
        logic ok;
        @(negedge clk);
        start = 1'b1;
        amount = AMT_W'(amt);
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_done_seen", 32'(ok), 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Stimulus
    initial begin
        int   hi;
        int   busy_cnt;
        int   done_cnt;
        logic seen;
        reset_n = 1'b0; start = 1'b0; amount = '0; refill = 1'b0;
        ack_en = 1'b1; ack_force = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ejects", 32'({eject_quarter, eject_dime, eject_nickel}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_short", 32'(short), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_remaining", 32'(remaining), 0);
        check("rst_q_count", 32'(q_count), 8);
        check("rst_d_count", 32'(d_count), 8);
        check("rst_n_count", 32'(n_count), 8);
        reset_n = 1'b1;

        // 13 units -> Q,Q,D,N
        push_eject(C_Q); push_eject(C_Q); push_eject(C_D); push_eject(C_N);
        push_done(1'b0, 0, 6, 7, 7);
        run_req(13);

        // Hopper never acknowledges -> fault after 255 cycles of eject
        ack_en = 1'b0;
        push_eject(C_N);
        push_fault(1, 6, 7, 7);
        @(negedge clk); start = 1'b1; amount = AMT_W'(1);
        @(negedge clk); start = 1'b0;
        hi = 0; seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (eject_nickel) hi++;
            if (fault) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("timeout_fault_seen", 32'(seen), 1);
        check("timeout_eject_cycles", hi, 255);
        @(negedge clk);
        check("fault_sticky", 32'(fault), 1);
        check("fault_nickel_low", 32'(eject_nickel), 0);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        check("refill_fault_clear", 32'(fault), 0);
        check("refill_busy", 32'(busy), 0);
        check("refill_q_count", 32'(q_count), 8);
        check("refill_d_count", 32'(d_count), 8);
        check("refill_n_count", 32'(n_count), 8);
        ack_en = 1'b1;

        // Use up every nickel
        for (int i = 0; i < 8; i++) begin
            push_eject(C_N);
            push_done(1'b0, 0, 8, 8, 7 - i);
            run_req(1);
        end

        // 6 units with no nickels: quarter only, no backtracking to dimes
        push_eject(C_Q);
        push_done(1'b1, 1, 7, 8, 0);
        run_req(6);

        // Over-range request: no eject, immediate short done
        push_done(1'b1, 21, 7, 8, 0);
        @(negedge clk); start = 1'b1; amount = AMT_W'(21);
        @(negedge clk); start = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            @(negedge clk);
        end
        check("overrange_busy_cycles", busy_cnt, 1);
        check("overrange_done_pulses", done_cnt, 1);

        // Zero request; second start while busy and ack in IDLE are ignored
        push_done(1'b0, 0, 7, 8, 0);
        @(negedge clk); start = 1'b1; amount = AMT_W'(0);
        @(negedge clk); start = 1'b1; amount = AMT_W'(5);
        @(negedge clk); start = 1'b0;
        ack_force = 1'b1;
        repeat (2) @(negedge clk);
        ack_force = 1'b0;
        repeat (3) @(negedge clk);
        check("zero_idle_busy", 32'(busy), 0);
        check("zero_remaining", 32'(remaining), 0);
        check("zero_short", 32'(short), 0);
        check("zero_q_count", 32'(q_count), 7);
        check("zero_d_count", 32'(d_count), 8);

        // Reset in the middle of a quarter eject
        ack_en = 1'b0;
        push_eject(C_Q);
        @(negedge clk); start = 1'b1; amount = AMT_W'(5);
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (eject_quarter) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midreset_eject_seen", 32'(seen), 1);
        repeat (3) @(negedge clk);
        check("midreset_eject_held", 32'(eject_quarter), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_eject_low", 32'(eject_quarter), 0);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_remaining", 32'(remaining), 0);
        check("midreset_q_count", 32'(q_count), 8);
        check("midreset_d_count", 32'(d_count), 8);
        check("midreset_n_count", 32'(n_count), 8);
        reset_n = 1'b1;
        ack_en = 1'b1;

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
